// File: rtl/instr_pkg.sv
// Shared instruction-format constants for the dispatch arbiter and lane FIFOs.
package instr_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;

  // Fixed instruction field positions
  localparam int DEST_MSB  = 4;
  localparam int DEST_LSB  = 0;
  localparam int SRCA_MSB  = 20;
  localparam int SRCA_LSB  = 16;
  localparam int SRCB_MSB  = 15;
  localparam int SRCB_LSB  = 11;
  localparam int ROUTE_MSB = 28;
  localparam int ROUTE_LSB = 27;

  // Route encodings used by the arbiter to pick a lane
  localparam logic [1:0] ROUTE_FIFO1 = 2'b10;
  localparam logic [1:0] ROUTE_FIFO2 = 2'b11;

endpackage

// File: rtl/instr_fifo_scoreboard.sv
// Destination-register scoreboard: one valid bit per FIFO slot, plus two
// probe ports that report whether any live entry writes the probed register.
module instr_fifo_scoreboard
  import instr_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [AW-1:0]                 wr_ptr_i,
  input  logic [AW-1:0]                 rd_ptr_i,
  input  logic [DEPTH-1:0][REG_AW-1:0]  dest_i,
  input  logic [REG_AW-1:0]             query_a_i,
  input  logic [REG_AW-1:0]             query_b_i,
  output logic                          hit_a_o,
  output logic                          hit_b_o
);

  logic [DEPTH-1:0] valid_q, valid_d;

  // Next valid bits: flush wipes all; otherwise clear the popped slot, then
  // set the pushed slot (push wins when full with pop shares one slot).
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      if (pop_i)  valid_d[rd_ptr_i] = 1'b0;
      if (push_i) valid_d[wr_ptr_i] = 1'b1;
    end
  end

  // Valid-bit register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Probe compare and OR-reduce over live entries; register 0 is not special
  always_comb begin
    hit_a_o = 1'b0;
    hit_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (dest_i[i] == query_a_i)) hit_a_o = 1'b1;
      if (valid_q[i] && (dest_i[i] == query_b_i)) hit_b_o = 1'b1;
    end
  end

endmodule

// File: rtl/instr_fifo.sv
// Per-lane FWFT instruction FIFO with sticky overflow and dest scoreboard.
// Handshake: the head transfers on a clock edge where out_valid && out_ready;
// out_valid does not depend on out_ready, and out_ready is ignored while empty.
module instr_fifo
  import instr_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = DEPTH - 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               flush,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic [CW-1:0]      count,
  output logic               overflow,
  input  logic [REG_AW-1:0]  query_a,
  input  logic [REG_AW-1:0]  query_b,
  output logic               hit_a,
  output logic               hit_b
);

  logic [INSTR_W-1:0]              mem_q [DEPTH];
  logic [AW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                   count_q, count_d;
  logic                            overflow_q, overflow_d;
  logic                            push, pop;
  logic [DEPTH-1:0][REG_AW-1:0]    dests;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign out_valid   = !empty;
  assign out_instr   = empty ? '0 : mem_q[rd_ptr_q];

  assign pop  = out_valid && out_ready;
  assign push = wr_en && (!full || pop);

  // Pointer, occupancy and overflow next state; flush overrides push/pop
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (wr_en && !push)    overflow_d = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Instruction storage; contents survive reset, liveness lives elsewhere
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= instr_in;
  end

  // Gather the dest field of every slot for the scoreboard compare
  always_comb begin
    for (int i = 0; i < DEPTH; i++) dests[i] = mem_q[i][DEST_MSB:DEST_LSB];
  end

  instr_fifo_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push && !flush),
    .pop_i     (pop && !flush),
    .flush_i   (flush),
    .wr_ptr_i  (wr_ptr_q),
    .rd_ptr_i  (rd_ptr_q),
    .dest_i    (dests),
    .query_a_i (query_a),
    .query_b_i (query_b),
    .hit_a_o   (hit_a),
    .hit_b_o   (hit_b)
  );

endmodule
